// File: rtl/balsa_mul8_sync_env_if.sv
// Handshake bundle between the synchronous SoC side, the async multiplier core
// and the environment block that bridges them.
interface balsa_mul8_sync_env_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
);
    // SoC operand port
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    // SoC result port
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_x;
    logic [WIDTH-1:0] out_y;
    logic [WIDTH-1:0] out_z;
    logic [CNT_W-1:0] txn_count;
    // Async core channels
    logic             activate_0r;
    logic             activate_0a;
    logic             x_0r;
    logic             x_0a;
    logic [WIDTH-1:0] x_0d;
    logic             y_0r;
    logic             y_0a;
    logic [WIDTH-1:0] y_0d;
    logic             z_0r;
    logic             z_0a;
    logic [WIDTH-1:0] z_0d;

    // Side that feeds operands, consumes results and plays the async core
    modport master (
        output in_valid, in_x, in_y, out_ready,
        output activate_0a, x_0r, y_0r, z_0r, z_0d,
        input  in_ready, out_valid, out_x, out_y, out_z, txn_count,
        input  activate_0r, x_0a, x_0d, y_0a, y_0d, z_0a
    );

    // The environment block itself
    modport slave (
        input  in_valid, in_x, in_y, out_ready,
        input  activate_0a, x_0r, y_0r, z_0r, z_0d,
        output in_ready, out_valid, out_x, out_y, out_z, txn_count,
        output activate_0r, x_0a, x_0d, y_0a, y_0d, z_0a
    );
endinterface

// File: rtl/balsa_mul8_sync_env.sv
// Clocked environment for a Balsa 4-phase bundled-data multiplier core.
// Operand pairs are held until the core has pulled both x and y; the pushed
// product is captured with the operands that produced it.
module balsa_mul8_sync_env #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input logic                  clk,
    input logic                  rst,
    balsa_mul8_sync_env_if.slave bus
);
    typedef enum logic [1:0] {PullIdle, PullDrive, PullAck} pull_st_e;
    typedef enum logic {PushIdle, PushAck} push_st_e;

    // Synchronizer chains: 0 = x_0r, 1 = y_0r, 2 = z_0r, 3 = activate_0a
    logic [3:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [3:0]                  async_in;
    logic [1:0]                  pull_req_s;
    logic                        z_req_s;
    logic                        unused_act_ack_s;

    // Operand holding register and in-flight copy (index 0 = x, 1 = y)
    logic                  pair_full_q, pair_full_d;
    logic [1:0][WIDTH-1:0] pair_q, pair_d;
    logic [1:0][WIDTH-1:0] infl_q, infl_d;
    logic                  in_ready, load, consume;

    // Pull channels (index 0 = x, 1 = y)
    pull_st_e              pull_st_q [2];
    pull_st_e              pull_st_d [2];
    logic [1:0]            pull_ack_q, pull_ack_d;
    logic [1:0]            served_q, served_d;
    logic [1:0][WIDTH-1:0] pull_dat_q, pull_dat_d;

    // Push channel and result register
    push_st_e         push_st_q, push_st_d;
    logic             z_ack_q, z_ack_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_x_q, out_x_d, out_y_q, out_y_d, out_z_q, out_z_d;
    logic [CNT_W-1:0] txn_q, txn_d;
    logic             act_q, act_d;

    assign async_in         = {bus.activate_0a, bus.z_0r, bus.y_0r, bus.x_0r};
    assign pull_req_s       = {sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};
    assign z_req_s          = sync_q[2][SYNC_STAGES-1];
    // Activate ack is synchronized for status only; no logic depends on it
    assign unused_act_ack_s = sync_q[3][SYNC_STAGES-1];

    assign in_ready = !pair_full_q && !rst;
    assign load     = bus.in_valid && in_ready;
    // Both pulls of this pair have completed their ack rise
    assign consume  = served_q[0] && served_q[1];

    // Shift async inputs through the synchronizers; activate stays high after reset
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], async_in[i]};
        end
        act_d = 1'b1;
    end

    // Operand register and the two pull handshakes
    always_comb begin
        pair_full_d = pair_full_q;
        pair_d      = pair_q;
        infl_d      = infl_q;
        pull_st_d   = pull_st_q;
        pull_ack_d  = pull_ack_q;
        served_d    = served_q;
        pull_dat_d  = pull_dat_q;

        for (int c = 0; c < 2; c++) begin
            unique case (pull_st_q[c])
                PullIdle: begin
                    // A request without a fresh pair is left unacknowledged
                    if (pull_req_s[c] && pair_full_q && !served_q[c]) begin
                        pull_st_d[c]  = PullDrive;
                        pull_dat_d[c] = pair_q[c];
                    end
                end
                PullDrive: begin
                    // Data was driven last cycle, so it is stable before the ack
                    pull_st_d[c]  = PullAck;
                    pull_ack_d[c] = 1'b1;
                    served_d[c]   = 1'b1;
                end
                PullAck: begin
                    if (!pull_req_s[c]) begin
                        pull_st_d[c]  = PullIdle;
                        pull_ack_d[c] = 1'b0;
                    end
                end
                default: pull_st_d[c] = PullIdle;
            endcase
        end

        if (consume) begin
            served_d    = 2'b00;
            pair_full_d = 1'b0;
            infl_d      = pair_q;
        end
        if (load) begin
            pair_full_d = 1'b1;
            pair_d[0]   = bus.in_x;
            pair_d[1]   = bus.in_y;
        end
    end

    // Push handshake, result register and transaction counter
    always_comb begin
        push_st_d   = push_st_q;
        z_ack_d     = z_ack_q;
        out_valid_d = out_valid_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_z_d     = out_z_q;
        txn_d       = txn_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (push_st_q)
            PushIdle: begin
                // An undrained result holds the core off until it is taken
                if (z_req_s && !out_valid_q) begin
                    push_st_d   = PushAck;
                    z_ack_d     = 1'b1;
                    out_valid_d = 1'b1;
                    out_z_d     = bus.z_0d;
                    out_x_d     = infl_q[0];
                    out_y_d     = infl_q[1];
                    txn_d       = txn_q + CNT_W'(1);
                end
            end
            PushAck: begin
                if (!z_req_s) begin
                    push_st_d = PushIdle;
                    z_ack_d   = 1'b0;
                end
            end
            default: push_st_d = PushIdle;
        endcase
    end

    // State registers; reset discards any in-flight pair and result
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= '0;
            act_q       <= 1'b0;
            pair_full_q <= 1'b0;
            pair_q      <= '0;
            infl_q      <= '0;
            pull_st_q   <= '{PullIdle, PullIdle};
            pull_ack_q  <= '0;
            served_q    <= '0;
            pull_dat_q  <= '0;
            push_st_q   <= PushIdle;
            z_ack_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_z_q     <= '0;
            txn_q       <= '0;
        end else begin
            sync_q      <= sync_d;
            act_q       <= act_d;
            pair_full_q <= pair_full_d;
            pair_q      <= pair_d;
            infl_q      <= infl_d;
            pull_st_q   <= pull_st_d;
            pull_ack_q  <= pull_ack_d;
            served_q    <= served_d;
            pull_dat_q  <= pull_dat_d;
            push_st_q   <= push_st_d;
            z_ack_q     <= z_ack_d;
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_z_q     <= out_z_d;
            txn_q       <= txn_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.activate_0r = act_q;
    assign bus.x_0a        = pull_ack_q[0];
    assign bus.x_0d        = pull_dat_q[0];
    assign bus.y_0a        = pull_ack_q[1];
    assign bus.y_0d        = pull_dat_q[1];
    assign bus.z_0a        = z_ack_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_x       = out_x_q;
    assign bus.out_y       = out_y_q;
    assign bus.out_z       = out_z_q;
    assign bus.txn_count   = txn_q;
endmodule

// File: tb/tb_balsa_mul8_sync_env.sv
// Bench for balsa_mul8_sync_env: plays the async core, feeds operand pairs and
// checks every delivered result against an expected-result queue.
module tb_balsa_mul8_sync_env;
    localparam int unsigned Width      = 8;
    localparam int unsigned SyncStages = 2;
    localparam int unsigned CntW       = 4;   // small so the counter wraps
    localparam int          Bound      = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;

    balsa_mul8_sync_env_if #(.WIDTH(Width), .CNT_W(CntW)) bus ();

    balsa_mul8_sync_env #(
        .WIDTH      (Width),
        .SYNC_STAGES(SyncStages),
        .CNT_W      (CntW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [23:0] exp_q[$];      // {x, y, x*y mod 256} in submission order
    int          model_txn = 0;
    int          sink_mode = 0; // 0 always ready, 1 random, 2 hold
    logic [7:0]  pulled [2];
    int          pull_lat [2];
    int          push_lat;
    int          ir_rises = 0;
    logic        ir_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic get_a(input int ch);
        return (ch == 0) ? bus.x_0a : bus.y_0a;
    endfunction

    function automatic logic [7:0] get_d(input int ch);
        return (ch == 0) ? bus.x_0d : bus.y_0d;
    endfunction

    task automatic set_req(input int ch, input logic v);
        if (ch == 0) bus.x_0r = v;
        else         bus.y_0r = v;
    endtask

    // Core activate ack simply follows the request
    always @(negedge clk) bus.activate_0a = bus.activate_0r;

    // in_ready rise counter
    always @(negedge clk) begin
        if (bus.in_ready && !ir_prev) ir_rises++;
        ir_prev = bus.in_ready;
    end

    // Result consumer: decide ready for the coming edge, then score a transfer
    always @(negedge clk) begin
        logic [23:0] e;
        if (sink_mode == 0)      bus.out_ready = 1'b1;
        else if (sink_mode == 1) bus.out_ready = ($urandom_range(0, 3) != 0);
        else                     bus.out_ready = 1'b0;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                model_txn++;
                check_eq("out_x", bus.out_x, e[23:16]);
                check_eq("out_y", bus.out_y, e[15:8]);
                check_eq("out_z", bus.out_z, e[7:0]);
                check_eq("txn_count", bus.txn_count, model_txn % (1 << CntW));
            end
        end
    end

    // Call at a negedge; waits for in_ready, then presents one pair
    task automatic submit(input logic [7:0] x, input logic [7:0] y, input bit expect_result);
        int         n = 0;
        logic [7:0] ez;
        while (!bus.in_ready && n < Bound) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            check_eq("in_ready timeout", 0, 1);
            return;
        end
        bus.in_x     = x;
        bus.in_y     = y;
        bus.in_valid = 1'b1;
        ez = 8'((int'(x) * int'(y)) % 256);
        if (expect_result) exp_q.push_back({x, y, ez});
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Core pull on one channel: full 4-phase cycle, data must precede ack
    task automatic pull(input int ch);
        int         n = 0;
        bit         got = 1'b0;
        logic [7:0] prev;
        prev = get_d(ch);
        set_req(ch, 1'b1);
        while (!got && n < Bound) begin
            @(negedge clk);
            n++;
            if (get_a(ch)) got = 1'b1;
            else           prev = get_d(ch);
        end
        if (!got) begin
            check_eq("pull ack timeout", 0, 1);
            set_req(ch, 1'b0);
            return;
        end
        pull_lat[ch] = n;
        pulled[ch]   = get_d(ch);
        check_eq("pull data stable before ack", get_d(ch), prev);
        set_req(ch, 1'b0);
        n = 0;
        while (get_a(ch) && n < Bound) begin
            @(negedge clk);
            n++;
        end
        if (get_a(ch)) check_eq("pull ack release timeout", 0, 1);
    endtask

    // Core push of the product of the pulled operands
    task automatic push(input int hold_cycles);
        int          n = 0;
        int          hi = 0;
        logic [15:0] p;
        p = 16'(pulled[0]) * 16'(pulled[1]);
        bus.z_0d = p[7:0];
        @(negedge clk);
        bus.z_0r = 1'b1;
        if (hold_cycles > 0) begin
            repeat (hold_cycles) begin
                @(negedge clk);
                if (bus.z_0a) hi++;
            end
            check_eq("z_0a held off by undrained result", hi, 0);
            sink_mode = 0;
        end
        while (!bus.z_0a && n < Bound) begin
            @(negedge clk);
            n++;
        end
        if (!bus.z_0a) check_eq("push ack timeout", 0, 1);
        push_lat = n;
        bus.z_0r = 1'b0;
        n = 0;
        while (bus.z_0a && n < Bound) begin
            @(negedge clk);
            n++;
        end
        if (bus.z_0a) check_eq("push ack release timeout", 0, 1);
    endtask

    // order: 0 simultaneous, 1 x then y, 2 y then x
    task automatic core_txn(input int order, input int hold_cycles);
        if (order == 0) begin
            fork
                pull(0);
                pull(1);
            join
        end else if (order == 1) begin
            pull(0);
            pull(1);
        end else begin
            pull(1);
            pull(0);
        end
        push(hold_cycles);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < Bound) begin
            @(negedge clk);
            n++;
        end
        check_eq("results outstanding", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout: errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        int          hi;
        int          r0;
        logic [7:0]  rx, ry;
        logic [15:0] stream [5];
        stream = '{16'h050F, 16'h000A, 16'h0A00, 16'hC802, 16'h02C8};

        bus.in_valid = 1'b0;
        bus.in_x     = '0;
        bus.in_y     = '0;
        bus.x_0r     = 1'b0;
        bus.y_0r     = 1'b0;
        bus.z_0r     = 1'b0;
        bus.z_0d     = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst out_valid", bus.out_valid, 0);
        check_eq("rst in_ready", bus.in_ready, 0);
        check_eq("rst x_0a", bus.x_0a, 0);
        check_eq("rst y_0a", bus.y_0a, 0);
        check_eq("rst z_0a", bus.z_0a, 0);
        check_eq("rst activate_0r", bus.activate_0r, 0);
        check_eq("rst txn_count", bus.txn_count, 0);
        check_eq("rst out_z", bus.out_z, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("activate_0r after reset", bus.activate_0r, 1);
        check_eq("in_ready after reset", bus.in_ready, 1);

        // 15*5 with latency checks
        sink_mode = 0;
        submit(8'd15, 8'd5, 1'b1);
        core_txn(0, 0);
        check_eq("x pull latency", pull_lat[0], SyncStages + 2);
        check_eq("y pull latency", pull_lat[1], SyncStages + 2);
        check_eq("push latency", push_lat, SyncStages + 1);
        wait_drain();

        // Stream of five
        for (int i = 0; i < 5; i++) begin
            rx = stream[i][7:0];
            ry = stream[i][15:8];
            submit(rx, ry, 1'b1);
            core_txn(i % 3, 0);
        end
        wait_drain();
        check_eq("txn_count after stream", bus.txn_count, 6);

        // Backpressure: second push waits until first result is taken
        sink_mode = 2;
        submit(8'd3, 8'd4, 1'b1);
        core_txn(0, 0);
        submit(8'd5, 8'd6, 1'b1);
        core_txn(0, 15);
        wait_drain();

        // Request with no pair stays unacknowledged
        fork
            pull(0);
            begin
                hi = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (bus.x_0a) hi++;
                end
                check_eq("x_0a without pair", hi, 0);
                submit(8'd7, 8'd3, 1'b1);
                pull(1);
            end
        join
        push(0);
        wait_drain();

        // y before x, single consumption
        submit(8'd12, 8'd11, 1'b1);
        r0 = ir_rises;
        core_txn(2, 0);
        repeat (3) @(negedge clk);
        check_eq("in_ready rises once", ir_rises - r0, 1);
        wait_drain();

        // Randomized operands, order and sink stalls
        sink_mode = 1;
        for (int i = 0; i < 30; i++) begin
            rx = 8'($urandom_range(0, 255));
            ry = 8'($urandom_range(0, 255));
            if (i == 0) begin rx = 8'd255; ry = 8'd255; end
            submit(rx, ry, 1'b1);
            core_txn(int'($urandom_range(0, 2)), 0);
        end
        sink_mode = 0;
        wait_drain();

        // Reset while x_0a is high and a result is undrained
        sink_mode = 2;
        submit(8'd6, 8'd6, 1'b1);
        core_txn(0, 0);
        submit(8'd4, 8'd4, 1'b0);
        bus.x_0r = 1'b1;
        hi = 0;
        while (!bus.x_0a && hi < Bound) begin
            @(negedge clk);
            hi++;
        end
        check_eq("x_0a before reset", bus.x_0a, 1);
        check_eq("out_valid before reset", bus.out_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid rst x_0a", bus.x_0a, 0);
        check_eq("mid rst z_0a", bus.z_0a, 0);
        check_eq("mid rst out_valid", bus.out_valid, 0);
        check_eq("mid rst activate_0r", bus.activate_0r, 0);
        check_eq("mid rst in_ready", bus.in_ready, 0);
        bus.x_0r = 1'b0;
        exp_q.delete();
        model_txn = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("activate_0r after mid reset", bus.activate_0r, 1);
        sink_mode = 0;
        submit(8'd9, 8'd9, 1'b1);
        core_txn(0, 0);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
